// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encodings,
// default hold limit and the circular priority search.
package rr_arbiter_4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_HOLD_DEF = 8;
  localparam int ARB_CNT_W_DEF    = 8;
  localparam int ARB_NUM_REQ      = 4;

  // Returns {found, index} of the first set request at or after ptr, wrapping mod 4.
  // Walking offsets from high to low lets the nearest offset win.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = ARB_NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Client-side bus of the arbiter: request/release in, grant status out.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_4_decoder_2x4.sv
// 2-to-4 one-hot decoder with enable; d0 is the index LSB, so index 1 drives y1.
module decoder_2x4 (
  input  logic en,
  input  logic d0,
  input  logic d1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);
  assign y0 = en & ~d1 & ~d0;
  assign y1 = en & ~d1 &  d0;
  assign y2 = en &  d1 & ~d0;
  assign y3 = en &  d1 &  d0;
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold limit; one idle cycle always
// separates consecutive grants.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int CNT_W    = ARB_CNT_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  rr_arbiter_4_if.slave bus
);

  arb_state_e       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       gnt_id_q;
  logic             gnt_valid_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  logic [2:0] pick;
  logic       owner_req;
  logic       hold_max;
  logic       release_now;
  logic [3:0] gnt_dec;

  assign pick        = rr_pick(bus.req, ptr_q);
  assign owner_req   = bus.req[gnt_id_q];
  assign hold_max    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_now = bus.done | ~owner_req | hold_max;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (pick[2]) begin
            state_q     <= GRANT;
            gnt_id_q    <= pick[1:0];
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
            ptr_q       <= pick[1:0] + 2'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_q     <= IDLE;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            // Forced release is flagged only when neither done nor a request drop caused it.
            timeout_q   <= hold_max & ~bus.done & owner_req;
          end else begin
            hold_cnt_q  <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  decoder_2x4 u_dec (
    .en (gnt_valid_q),
    .d0 (gnt_id_q[0]),
    .d1 (gnt_id_q[1]),
    .y0 (gnt_dec[0]),
    .y1 (gnt_dec[1]),
    .y2 (gnt_dec[2]),
    .y3 (gnt_dec[3])
  );

  assign bus.gnt       = gnt_dec;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: vector table for reset/rotation/wrap,
// hand sequences for timeout, simultaneous release and reset mid-grant.
module tb_rr_arbiter_4;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  rr_arbiter_4_if bus();

  rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  // Drive one cycle of inputs, let one rising edge consume them, check on the falling edge.
  task automatic step(input string nm, input logic rst, input logic [3:0] rq, input logic dn,
                      input logic [3:0] eg, input logic [1:0] eid, input logic ev, input logic eto);
    reset    = rst;
    bus.req  = rq;
    bus.done = dn;
    @(posedge clock);
    @(negedge clock);
    n_total++;
    if (bus.gnt === eg && bus.gnt_id === eid && bus.gnt_valid === ev && bus.timeout === eto)
      n_pass++;
    else
      $display("FAIL %s: got gnt=%b id=%0d vld=%b to=%b, expected gnt=%b id=%0d vld=%b to=%b",
               nm, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, eg, eid, ev, eto);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    //            rst   req      done  gnt      id    vld   to
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset held
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // first grant after reset
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0}; // rotation 0,1,2,3
    vecs[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0}; // skip to 2, ptr->3
    vecs[11] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0}; // ptr=3 picks 3 over 0
    vecs[13] = '{1'b0, 4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // wrapped ptr=0
    vecs[15] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // owner req drop
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle, no requests
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0}; // sole requester rewins
    vecs[19] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // ptr=1
    vecs[23] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0}; // other reqs ignored
    vecs[24] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};

    @(negedge clock);
    for (int i = 0; i < NV; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].done,
           vecs[i].gnt, vecs[i].id, vecs[i].vld, vecs[i].to);

    // Timeout: ptr=2, client 1 alone holds for exactly 8 cycles.
    for (int k = 0; k < 8; k++)
      step($sformatf("to_hold%0d", k), 1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("to_pulse", 1'b0, 4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1);
    step("to_regrant", 1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

    // done coincides with hold_cnt==7: release without timeout.
    for (int k = 1; k < 8; k++)
      step($sformatf("dn_hold%0d", k), 1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("dn_at_max", 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("dn_after", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner drops request on its first grant cycle.
    step("drop_grant", 1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("drop_rel", 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);

    // Reset mid-grant at hold_cnt=3 (ptr=2 -> client 2 wins, ptr becomes 3).
    step("rm_grant", 1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++)
      step($sformatf("rm_hold%0d", k), 1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rm_reset", 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rm_ptr0", 1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rm_rel", 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rm_req3", 1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
